// File: rtl/frame_assembler_if.sv
// Command/frame bus for frame_assembler: word writes and send commands in,
// committed frames out, plus sticky error and commit counter.
interface frame_assembler_if #(
    parameter int DEPTH  = 64,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 15
);
    localparam int CMD_W = 1 + ADDR_W + WORD_W;

    logic [CMD_W-1:0] cmd;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DEPTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             wr_err;
    logic [15:0]      frame_cnt;

    modport master (
        output cmd, cmd_valid, dout_ready,
        input  cmd_ready, dout, dout_valid, wr_err, frame_cnt
    );

    modport slave (
        input  cmd, cmd_valid, dout_ready,
        output cmd_ready, dout, dout_valid, wr_err, frame_cnt
    );
endinterface

// File: rtl/frame_assembler.sv
// Assembles a DEPTH-bit frame from indexed word writes and presents it on send.
// FRAME_ASM_DOUBLE_BUF_EN: separate output register so writes never stall.
module frame_assembler #(
    parameter int DEPTH  = 64,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    frame_assembler_if.slave  bus
);
    localparam int NWORDS = DEPTH / WORD_W;
    localparam int CMD_W  = 1 + ADDR_W + WORD_W;
    localparam logic [ADDR_W:0] NW_C = (ADDR_W+1)'(NWORDS);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state, state_nxt;
    logic                send, acc, wr_acc, sd_acc, in_range, take;
    logic [ADDR_W-1:0]   idx;
    logic [WORD_W-1:0]   data;
    logic [DEPTH-1:0]    back_buf;
    logic [15:0]         cnt_q;
    logic                err_q;

    assign send     = bus.cmd[CMD_W-1];
    assign idx      = bus.cmd[CMD_W-2:WORD_W];
    assign data     = bus.cmd[WORD_W-1:0];
    assign in_range = ({1'b0, idx} < NW_C);
    assign acc      = bus.cmd_valid && bus.cmd_ready;
    assign wr_acc   = acc && !send;
    assign sd_acc   = acc && send;
    assign take     = bus.dout_valid && bus.dout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (sd_acc) state_nxt = FULL;
            FULL:    if (!sd_acc && bus.dout_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    assign bus.dout_valid = (state == FULL);

    // Back buffer is never cleared on commit; unwritten words carry over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back_buf <= '0;
        end else if (wr_acc && in_range) begin
            for (int w = 0; w < NWORDS; w++)
                if (idx == ADDR_W'(w)) back_buf[w*WORD_W +: WORD_W] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (wr_acc && !in_range) err_q <= 1'b1;
            if (sd_acc)              cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.wr_err    = err_q;
    assign bus.frame_cnt = cnt_q;

`ifdef FRAME_ASM_DOUBLE_BUF_EN
    logic [DEPTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (sd_acc) dout_q <= back_buf;
    end

    assign bus.dout      = dout_q;
    // Only a send into an unconsumed frame must wait; writes go to the back buffer.
    assign bus.cmd_ready = !(send && bus.dout_valid && !bus.dout_ready);
`else
    // The presented frame is the buffer itself, so nothing may touch it until taken.
    assign bus.dout      = back_buf;
    assign bus.cmd_ready = !bus.dout_valid || bus.dout_ready;
`endif

    logic unused_take;
    assign unused_take = take;
endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler with a reference model and frame scoreboard.
module tb_frame_assembler;
`ifdef FRAME_ASM_DOUBLE_BUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] m_buf;
    logic [63:0] exp_q[$];
    logic [15:0] m_cnt;
    logic        m_err;

    frame_assembler_if #(.DEPTH(64), .WORD_W(16), .ADDR_W(15)) bus ();

    frame_assembler #(.DEPTH(64), .WORD_W(16), .ADDR_W(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_buf = '0;
        m_cnt = '0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ":dout_valid"}, 64'(bus.dout_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk({tag, ":dout"}, bus.dout, exp_q[0]);
        chk({tag, ":frame_cnt"}, 64'(bus.frame_cnt), 64'(m_cnt));
        chk({tag, ":wr_err"}, 64'(bus.wr_err), 64'(m_err));
    endtask

    // One clock of stimulus; the model decides acceptance independently of the DUT.
    task automatic step(input string tag, input bit v, input bit s,
                        input logic [14:0] i, input logic [15:0] d, input bit rdy);
        bit full, er, acc;
        @(negedge clk);
        bus.cmd_valid  = v;
        bus.cmd        = {s, i, d};
        bus.dout_ready = rdy;
        #1;
        full = (exp_q.size() != 0);
        er   = DBUF ? !(s && full && !rdy) : (!full || rdy);
        if (v) chk({tag, ":cmd_ready"}, 64'(bus.cmd_ready), 64'(er));
        acc = v && er;
        if (acc && !s) begin
            if (i < 15'd4) m_buf[i*16 +: 16] = d;
            else           m_err = 1'b1;
        end
        if (full && rdy) void'(exp_q.pop_front());
        if (acc && s) begin
            exp_q.push_back(m_buf);
            m_cnt++;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk_outputs(tag);
    endtask

    initial begin
        bus.cmd        = '0;
        bus.cmd_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        model_reset();
        #3;
        chk("reset:dout", bus.dout, 64'h0);
        chk("reset:dout_valid", 64'(bus.dout_valid), 64'h0);
        chk("reset:frame_cnt", 64'(bus.frame_cnt), 64'h0);
        chk("reset:wr_err", 64'(bus.wr_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame assembly
        step("w0", 1, 0, 15'd0, 16'h1111, 0);
        step("w1", 1, 0, 15'd1, 16'h2222, 0);
        step("w2", 1, 0, 15'd2, 16'h3333, 0);
        step("w3", 1, 0, 15'd3, 16'h4444, 0);
        step("sendA", 1, 1, 15'd0, 16'h0, 0);
        chk("sendA:const", bus.dout, 64'h4444_3333_2222_1111);
        chk("sendA:cnt1", 64'(bus.frame_cnt), 64'd1);
        step("takeA", 0, 0, 15'd0, 16'h0, 1);

        // Out-of-range write is dropped and flagged
        step("bad_w7", 1, 0, 15'd7, 16'hDEAD, 0);
        chk("bad_w7:err", 64'(bus.wr_err), 64'd1);
        chk("bad_w7:buf", bus.dout, 64'h4444_3333_2222_1111);

        // Backpressure: consumer holds off while a new frame is built
        step("w0b", 1, 0, 15'd0, 16'h5555, 0);
        step("sendA2", 1, 1, 15'd0, 16'h0, 0);
        step("bp_w1", 1, 0, 15'd1, 16'h6666, 0);
        step("bp_send", 1, 1, 15'd0, 16'h0, 0);
        step("bp_hold", 0, 0, 15'd0, 16'h0, 0);
        chk("bp_hold:dout", bus.dout, 64'h4444_3333_2222_5555);
        step("sendB", 1, 1, 15'd0, 16'h0, 1);
        step("bp_w2", 1, 0, 15'd2, 16'h7777, 0);
        step("sendC", 1, 1, 15'd0, 16'h0, 1);
        step("takeC", 0, 0, 15'd0, 16'h0, 1);
        step("idle", 0, 0, 15'd0, 16'h0, 0);

        // Reset mid-frame
        step("rw0", 1, 0, 15'd0, 16'hAAAA, 0);
        step("rw1", 1, 0, 15'd1, 16'hBBBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst:dout", bus.dout, 64'h0);
        chk("rst:dout_valid", 64'(bus.dout_valid), 64'h0);
        chk("rst:frame_cnt", 64'(bus.frame_cnt), 64'h0);
        chk("rst:wr_err", 64'(bus.wr_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_send", 1, 1, 15'd0, 16'h0, 1);
        chk("rst_send:dout0", bus.dout, 64'h0);

        // Counter wrap: back-to-back sends from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.cmd        = {1'b1, 15'd0, 16'h0};
        bus.cmd_valid  = 1'b1;
        bus.dout_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap:ffff", 64'(bus.frame_cnt), 64'h0000_FFFF);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("wrap:zero", 64'(bus.frame_cnt), 64'h0);
        chk("wrap:valid", 64'(bus.dout_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
